alu_uart_frame_ctrl: RTL

Parametrised successor of the single-byte ALU/UART interface. It sits between the UART FIFOs and the ALU. It parses a framed request from the RX FIFO: a sync byte, then the opcode, then multi-byte operands A and B. It drives the ALU with the parsed values, then streams back the result bytes followed by a status byte through the TX FIFO. Operand width is no longer tied to the UART data width, and the block adds a sync byte, an inter-byte timeout and a status reply.

---
 rtl/alu_uart_frame_ctrl.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_uart_frame_ctrl.sv
// alu_uart_frame_ctrl
// Frame parser / reply generator between the UART FIFOs and an ALU.
// Request frame : SYNC_BYTE, opcode, A (NBYTES, little-endian), B (NBYTES, little-endian)
// Reply         : result (NBYTES, little-endian, zero-padded), status {0.., zero}
// An inter-byte timeout inside a request frame abandons the frame silently
// apart from a one-cycle o_timeout_tick pulse.

module alu_uart_frame_ctrl #(
  parameter int              DBIT      = 8,
  parameter int              NB_OP     = 6,
  parameter int              NB_AB     = 16,
  parameter logic [DBIT-1:0] SYNC_BYTE = 8'hA5,
  parameter int              TIMEOUT   = 1000
) (
  input  logic             clock,
  input  logic             i_reset,
  // RX FIFO side
  input  logic             i_rx_empty,
  input  logic [DBIT-1:0]  i_r_data,
  output logic             o_rd_uart,
  // TX FIFO side
  input  logic             i_tx_full,
  output logic [DBIT-1:0]  o_w_data,
  output logic             o_wr_uart,
  // ALU side
  output logic [NB_AB-1:0] o_alu_a,
  output logic [NB_AB-1:0] o_alu_b,
  output logic [NB_OP-1:0] o_alu_op,
  input  logic [NB_AB-1:0] i_alu_result,
  // status
  output logic             o_busy,
  output logic             o_timeout_tick
);

  localparam int NBYTES = (NB_AB + DBIT - 1) / DBIT;
  localparam int WW     = NBYTES * DBIT;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_OP,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_SEND_RES,
    S_SEND_STAT
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              gap_q;
  logic [NB_OP-1:0]  op_q, op_d;
  logic [NB_AB-1:0]  a_q, a_d;
  logic [NB_AB-1:0]  b_q, b_d;
  logic [NB_AB-1:0]  res_q, res_d;
  logic              zero_q, zero_d;
  logic              busy_q;

  logic              rx_state;
  logic              tmo_state;
  logic              tx_state;
  logic              rd;
  logic              wr;
  logic              expire;
  logic [WW-1:0]     fill_w;
  logic [WW-1:0]     res_wide;
  logic [DBIT-1:0]   tx_byte;

  // Handshake strobes: pops never back-to-back, pushes only when TX has room.
  always_comb begin
    rx_state  = (state_q == S_IDLE) || (state_q == S_GET_OP) ||
                (state_q == S_GET_A) || (state_q == S_GET_B);
    tmo_state = (state_q == S_GET_OP) || (state_q == S_GET_A) ||
                (state_q == S_GET_B);
    tx_state  = (state_q == S_SEND_RES) || (state_q == S_SEND_STAT);
    rd        = rx_state && !i_rx_empty && !gap_q && !i_reset;
    // A byte waiting at expiry suppresses the timeout; it is popped instead.
    expire    = tmo_state && (tmo_q == TMO_LAST) && i_rx_empty && !i_reset;
    wr        = tx_state && !i_tx_full && !i_reset;
  end

  // Outgoing byte: selected result byte or the status byte, stable while stalled.
  always_comb begin
    res_wide = WW'(res_q);
    tx_byte  = '0;
    if (state_q == S_SEND_RES) begin
      tx_byte = res_wide[int'(cnt_q) * DBIT +: DBIT];
    end else if (state_q == S_SEND_STAT) begin
      tx_byte = DBIT'(zero_q);
    end
  end

  // Next-state, operand assembly and counter logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    zero_d  = zero_q;

    // Little-endian byte insert into the operand currently being received.
    fill_w = WW'((state_q == S_GET_B) ? b_q : a_q);
    fill_w[int'(cnt_q) * DBIT +: DBIT] = i_r_data;

    if (tmo_state && (tmo_q != TMO_LAST)) begin
      tmo_d = tmo_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (rd && (i_r_data == SYNC_BYTE)) begin
          state_d = S_GET_OP;
        end
      end

      S_GET_OP: begin
        if (rd) begin
          op_d    = i_r_data[NB_OP-1:0];
          a_d     = '0;
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = S_GET_A;
        end else if (expire) begin
          tmo_d   = '0;
          state_d = S_IDLE;
        end
      end

      S_GET_A: begin
        if (rd) begin
          a_d   = fill_w[NB_AB-1:0];
          tmo_d = '0;
          if (cnt_q == LAST_BYTE) begin
            cnt_d   = '0;
            b_d     = '0;
            state_d = S_GET_B;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (expire) begin
          tmo_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      S_GET_B: begin
        if (rd) begin
          b_d   = fill_w[NB_AB-1:0];
          tmo_d = '0;
          if (cnt_q == LAST_BYTE) begin
            cnt_d   = '0;
            state_d = S_EXEC;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (expire) begin
          tmo_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      S_EXEC: begin
        res_d   = i_alu_result;
        zero_d  = (i_alu_result == '0);
        cnt_d   = '0;
        state_d = S_SEND_RES;
      end

      S_SEND_RES: begin
        if (wr) begin
          if (cnt_q == LAST_BYTE) begin
            cnt_d   = '0;
            state_d = S_SEND_STAT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_SEND_STAT: begin
        if (wr) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tmo_d   = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    // NOTE: registered state uses non-blocking assignments so all flops update together.
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      gap_q   <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      gap_q   <= rd;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign o_rd_uart      = rd;
  assign o_wr_uart      = wr;
  assign o_w_data       = i_reset ? '0 : tx_byte;
  assign o_alu_a        = a_q;
  assign o_alu_b        = b_q;
  assign o_alu_op       = op_q;
  assign o_busy         = busy_q;
  assign o_timeout_tick = expire;

endmodule
